// File: rtl/str_decim_if.sv
// Streaming sample interface for the decimator: upstream valid/ready pair on
// the input side and downstream valid/ready pair on the output side.
//
// Handshake: a word moves across a valid/ready pair on every rising clock
// edge where valid and ready are both 1. The producer holds data and valid
// stable while valid=1 and ready=0; ready may depend combinationally on the
// consumer's state but never on the same pair's valid.
interface str_decim_if #(
  parameter int DW = 12
);
  logic signed [DW-1:0] in;
  logic                 ivalid;
  logic                 iready;
  logic signed [DW-1:0] out;
  logic                 ovalid;
  logic                 oready;

  // Block side: consumes in/ivalid and oready, produces iready/out/ovalid.
  modport slave (
    input  in,
    input  ivalid,
    input  oready,
    output iready,
    output out,
    output ovalid
  );

  // Environment side: the source/sink that surrounds the block.
  modport master (
    output in,
    output ivalid,
    output oready,
    input  iready,
    input  out,
    input  ovalid
  );
endinterface

// File: rtl/str_decim.sv
// Block-mean decimator: sums N=2^LOG2N accepted samples and emits their mean
// (round-half-up or floor) once per block, with a one-deep output register.
module str_decim #(
  parameter int DW    = 12,
  parameter int LOG2N = 2,
  parameter int ROUND = 1
) (
  input  logic        clk,
  input  logic        rst,
  str_decim_if.slave  bus
);

  localparam int N  = 1 << LOG2N;
  localparam int AW = DW + LOG2N;
  localparam int CW = (LOG2N > 0) ? LOG2N : 1;
  // Half an LSB of the shifted result; zero for floor mode and for N=1.
  localparam logic [AW:0] RND = (ROUND != 0) ? (AW+1)'((1 << LOG2N) >> 1) : '0;

  logic signed [AW-1:0] r_acc;
  logic        [CW-1:0] r_cnt;
  logic signed [DW-1:0] r_out;
  logic                 r_ovalid;

  logic                 w_iready;
  logic                 w_accept;
  logic                 w_last;
  logic signed [AW:0]   w_sum;
  logic signed [AW:0]   w_rnd;
  logic signed [AW:0]   w_shift;
  logic        [DW-1:0] w_res;

  // Input handshake and end-of-block detection.
  always_comb begin
    w_iready = !r_ovalid || bus.oready;
    w_accept = bus.ivalid && w_iready;
    w_last   = (r_cnt == CW'(N - 1));
  end

  // Running sum including the current sample, then rounding and scaling.
  // One guard bit above the accumulator keeps the rounding add exact.
  always_comb begin
    w_sum   = {r_acc[AW-1], r_acc} + {{(LOG2N+1){bus.in[DW-1]}}, bus.in};
    w_rnd   = w_sum + RND;
    w_shift = w_rnd >>> LOG2N;
    w_res   = DW'(w_shift);
  end

  // Accumulator, sample counter and output register; reset wins over all.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc    <= '0;
      r_cnt    <= '0;
      r_out    <= '0;
      r_ovalid <= 1'b0;
    end else begin
      if (r_ovalid && bus.oready) begin
        r_ovalid <= 1'b0;
      end
      if (w_accept) begin
        if (w_last) begin
          r_out    <= w_res;
          r_ovalid <= 1'b1;
          r_acc    <= '0;
          r_cnt    <= '0;
        end else begin
          r_acc <= w_sum[AW-1:0];
          r_cnt <= r_cnt + 1'b1;
        end
      end
    end
  end

  // Drive the interface outputs.
  always_comb begin
    bus.iready = w_iready;
    bus.out    = r_out;
    bus.ovalid = r_ovalid;
  end

endmodule

// File: tb/tb_str_decim.sv
// Directed bench for str_decim (DW=12, LOG2N=2). Two instances share one
// stimulus stream: one with round-half-up, one with floor.
module tb_str_decim;

  localparam int DW = 12;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic signed [DW-1:0] drv_in     = '0;
  logic                 drv_ivalid = 1'b0;
  logic                 drv_oready = 1'b1;

  int total = 0;
  int bad   = 0;

  str_decim_if #(.DW(DW)) if_r1 ();
  str_decim_if #(.DW(DW)) if_r0 ();

  assign if_r1.in     = drv_in;
  assign if_r1.ivalid = drv_ivalid;
  assign if_r1.oready = drv_oready;
  assign if_r0.in     = drv_in;
  assign if_r0.ivalid = drv_ivalid;
  assign if_r0.oready = drv_oready;

  str_decim #(.DW(DW), .LOG2N(2), .ROUND(1)) u_r1 (
    .clk (clk),
    .rst (rst),
    .bus (if_r1)
  );

  str_decim #(.DW(DW), .LOG2N(2), .ROUND(0)) u_r0 (
    .clk (clk),
    .rst (rst),
    .bus (if_r0)
  );

  // Clock
  always #5 clk = ~clk;

  // Comparison helper
  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Advance one cycle; inputs are changed and outputs read 1 time unit
  // after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic feed(input int v);
    drv_in     = DW'(v);
    drv_ivalid = 1'b1;
    tick();
  endtask

  task automatic idle();
    drv_ivalid = 1'b0;
    tick();
  endtask

  // Vector table
  typedef struct {
    int s[4];
    int exp_r1;
    int exp_r0;
  } vec_t;

  vec_t vecs[8];

  // Ramp scoreboard
  logic [DW-1:0] exp_q1[$];
  logic [DW-1:0] exp_q0[$];
  bit mon_en  = 1'b0;
  int mon_cnt = 0;

  // Monitor: compare every output handed over during the ramp run.
  always @(negedge clk) begin
    if (mon_en && if_r1.ovalid) begin
      mon_cnt++;
      if (exp_q1.size() == 0) begin
        chk("ramp_r1_unexpected", 1, 0);
      end else begin
        chk("ramp_r1_out", int'($signed(if_r1.out)), int'($signed(exp_q1.pop_front())));
      end
      if (!if_r0.ovalid) begin
        chk("ramp_r0_ovalid", 0, 1);
      end else if (exp_q0.size() == 0) begin
        chk("ramp_r0_unexpected", 1, 0);
      end else begin
        chk("ramp_r0_out", int'($signed(if_r0.out)), int'($signed(exp_q0.pop_front())));
      end
    end
  end

  initial begin
    vecs[0] = '{s:'{4, 8, 12, 16},          exp_r1: 10,    exp_r0: 10};
    vecs[1] = '{s:'{-1, -1, -1, -2},        exp_r1: -1,    exp_r0: -2};
    vecs[2] = '{s:'{2047, 2047, 2047, 2047}, exp_r1: 2047, exp_r0: 2047};
    vecs[3] = '{s:'{-2048, -2048, -2048, -2048}, exp_r1: -2048, exp_r0: -2048};
    vecs[4] = '{s:'{1, 2, 3, 4},            exp_r1: 3,     exp_r0: 2};
    vecs[5] = '{s:'{0, 0, 0, -1},           exp_r1: 0,     exp_r0: -1};
    vecs[6] = '{s:'{-3, -3, -3, -3},        exp_r1: -3,    exp_r0: -3};
    vecs[7] = '{s:'{100, -50, 7, 1},        exp_r1: 15,    exp_r0: 14};

    // Reset state
    rst = 1'b1;
    drv_in = 12'sd55;
    drv_ivalid = 1'b1;
    tick();
    tick();
    chk("rst_ovalid", int'(if_r1.ovalid), 0);
    chk("rst_out", int'($signed(if_r1.out)), 0);
    chk("rst_iready", int'(if_r1.iready), 1);
    chk("rst_r0_ovalid", int'(if_r0.ovalid), 0);
    rst = 1'b0;
    drv_ivalid = 1'b0;
    tick();
    chk("post_rst_ovalid", int'(if_r1.ovalid), 0);

    // Table-driven blocks with oready=1
    drv_oready = 1'b1;
    for (int v = 0; v < 8; v++) begin
      for (int k = 0; k < 4; k++) begin
        feed(vecs[v].s[k]);
        if (k < 3) chk($sformatf("v%0d_mid_ovalid%0d", v, k), int'(if_r1.ovalid), 0);
      end
      chk($sformatf("v%0d_r1_ovalid", v), int'(if_r1.ovalid), 1);
      chk($sformatf("v%0d_r1_out", v), int'($signed(if_r1.out)), vecs[v].exp_r1);
      chk($sformatf("v%0d_r0_ovalid", v), int'(if_r0.ovalid), 1);
      chk($sformatf("v%0d_r0_out", v), int'($signed(if_r0.out)), vecs[v].exp_r0);
      idle();
      chk($sformatf("v%0d_drop_ovalid", v), int'(if_r1.ovalid), 0);
    end

    // Gaps with ivalid=0 do not advance the count
    feed(8);
    idle();
    idle();
    feed(8);
    idle();
    feed(8);
    chk("gap_early_ovalid", int'(if_r1.ovalid), 0);
    feed(16);
    chk("gap_ovalid", int'(if_r1.ovalid), 1);
    chk("gap_out", int'($signed(if_r1.out)), 10);
    idle();

    // Backpressure: output held, no input consumed
    drv_oready = 1'b0;
    feed(4); feed(8); feed(12); feed(16);
    chk("bp_ovalid", int'(if_r1.ovalid), 1);
    chk("bp_out", int'($signed(if_r1.out)), 10);
    drv_in = 12'sd999;
    drv_ivalid = 1'b1;
    #1;
    for (int c = 0; c < 10; c++) begin
      chk($sformatf("bp_iready%0d", c), int'(if_r1.iready), 0);
      chk($sformatf("bp_hold_ovalid%0d", c), int'(if_r1.ovalid), 1);
      chk($sformatf("bp_hold_out%0d", c), int'($signed(if_r1.out)), 10);
      tick();
    end
    drv_in = 12'sd20;
    drv_oready = 1'b1;
    #1;
    chk("bp_release_iready", int'(if_r1.iready), 1);
    tick();
    chk("bp_taken_ovalid", int'(if_r1.ovalid), 0);
    feed(20); feed(20); feed(20);
    chk("bp_resume_ovalid", int'(if_r1.ovalid), 1);
    chk("bp_resume_out", int'($signed(if_r1.out)), 20);
    chk("bp_resume_r0_out", int'($signed(if_r0.out)), 20);
    idle();

    // Reset mid-block discards the partial sum
    feed(500); feed(500);
    drv_ivalid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_ovalid", int'(if_r1.ovalid), 0);
    feed(100); feed(100); feed(100);
    chk("midrst_early_ovalid", int'(if_r1.ovalid), 0);
    feed(100);
    chk("midrst_ovalid_after", int'(if_r1.ovalid), 1);
    chk("midrst_r1_out", int'($signed(if_r1.out)), 100);
    chk("midrst_r0_out", int'($signed(if_r0.out)), 100);
    idle();

    // Continuous ramp for 400 cycles
    mon_en = 1'b1;
    drv_oready = 1'b1;
    begin
      int gsum = 0;
      for (int k = 0; k < 400; k++) begin
        int v = k - 200;
        gsum += v;
        if ((k % 4) == 3) begin
          exp_q1.push_back(DW'((gsum + 2) >>> 2));
          exp_q0.push_back(DW'(gsum >>> 2));
          gsum = 0;
        end
        feed(v);
      end
    end
    idle();
    idle();
    mon_en = 1'b0;
    chk("ramp_count", mon_cnt, 100);
    chk("ramp_q1_left", exp_q1.size(), 0);
    chk("ramp_q0_left", exp_q0.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/str_decim.md
STR_DECIM -- requirements
Module: str_decim

Interface
REQ-001 The block SHALL have parameter DW, default 12, giving the signed sample width in and out.
REQ-002 The block SHALL have parameter LOG2N, default 2, giving the decimation factor N=2^LOG2N; legal range 0..8.
REQ-003 The block SHALL have parameter ROUND, default 1, where 1 selects round-half-up and 0 selects floor.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-006 The block SHALL have port in, input, DW bits, signed: input sample, typically the FIR output.
REQ-007 The block SHALL have port ivalid, input, 1 bit: in is valid.
REQ-008 The block SHALL have port iready, output, 1 bit: the block can accept in this cycle.
REQ-009 The block SHALL have port out, output, DW bits, signed: the decimated mean sample.
REQ-010 The block SHALL have port ovalid, output, 1 bit: out is valid.
REQ-011 The block SHALL have port oready, input, 1 bit: the downstream stage accepts out.

Function
REQ-012 The block SHALL accept an input sample only in a cycle where ivalid and iready are both 1.
REQ-013 The block SHALL drive iready = !ovalid | oready, combinationally.
REQ-014 The block SHALL add each accepted sample into a signed accumulator of DW+LOG2N bits, so no overflow can occur.
REQ-015 The block SHALL keep a sample counter cnt in 0..N-1 that increments on each accept and wraps to 0 after the N-th accept.
REQ-016 On the accept where cnt==N-1, the block SHALL compute sum=acc+in, register the result into out, set ovalid=1, clear acc to 0 and set cnt to 0, all on the same edge.
REQ-017 With ROUND=1, the result SHALL be (sum + 2^(LOG2N-1)) >>> LOG2N, where >>> is an arithmetic shift.
REQ-018 With ROUND=0, or with LOG2N=0, the result SHALL be sum >>> LOG2N.
REQ-019 The result SHALL always fit in DW bits and SHALL be truncated to DW bits without saturation logic.
REQ-020 Latency SHALL be exactly 1 cycle: ovalid rises on the edge that accepts the N-th sample.
REQ-021 The out and ovalid outputs SHALL hold stable while ovalid=1 and oready=0.
REQ-022 While ovalid=1 and oready=0, iready SHALL be 0, and acc and cnt SHALL hold.
REQ-023 In a cycle with ovalid=1 and oready=1 and no completing accept, ovalid SHALL go to 0 on the next edge.
REQ-024 When the current output is taken and a new block completes in the same cycle, out SHALL load the new result and ovalid SHALL stay 1, with no bubble.
REQ-025 With ivalid=1 and oready=1 continuously, the block SHALL produce exactly one output every N cycles.
REQ-026 Input samples with ivalid=0 SHALL be ignored and SHALL NOT advance cnt.

Reset
REQ-027 While rst=1, the block SHALL set out=0, ovalid=0, acc=0 and cnt=0; iready then reads 1.
REQ-028 Reset asserted mid-block SHALL discard the partial sum, so the first block after reset starts from the next accepted sample.
REQ-029 Reset SHALL take priority over any concurrent accept or output handshake.

Verification (DW=12, LOG2N=2 unless noted)
REQ-030 The bench SHALL cover: ROUND=1, oready=1, inputs 4, 8, 12, 16 on consecutive cycles -> out=10 with ovalid=1 on the cycle after the 4th accept, then ovalid=0.
REQ-031 The bench SHALL cover: inputs -1, -1, -1, -2 (sum -5) -> out=-2 with ROUND=0, and out=-1 with ROUND=1.
REQ-032 The bench SHALL cover: four samples of 2047 -> out=2047; four samples of -2048 -> out=-2048, in both ROUND modes.
REQ-033 The bench SHALL cover: oready=0 after an output -> iready=0, out and ovalid held for 10 cycles, no input consumed; then oready=1 for one cycle -> that output is taken and accepting resumes.
REQ-034 The bench SHALL cover: two samples of 500, then rst for 1 cycle, then four samples of 100 -> first output after reset is 100.
REQ-035 The bench SHALL cover: continuous ivalid=1 and oready=1 for 400 cycles with a ramp input -> exactly 100 outputs, each the mean of its 4-sample group, with no input dropped.
